// File: rtl/nonce_report_queue.sv
// Golden-nonce report queue: buffers hits from the hash core in a small FIFO and feeds
// them one per send/busy handshake to mipi_tx, with an idle "yako" heartbeat.
module nonce_report_queue #(
  parameter int unsigned DEPTH_LOG2  = 3,
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned HB_CYCLES   = 16777216,
  parameter logic [31:0] HB_WORD     = 32'h79616B6F
) (
  input  logic                hash_clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                nonce_valid,
  input  logic [31:0]         nonce_in,
  input  logic                tx_busy,
  output logic                tx_send,
  output logic [31:0]         tx_data,
  output logic [DEPTH_LOG2:0] fifo_count,
  output logic [7:0]          overflow_cnt,
  output logic                timeout_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned HB_W  = (HB_CYCLES > 1) ? $clog2(HB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'((HB_CYCLES > 0) ? HB_CYCLES - 1 : 0);
  localparam bit               HB_EN    = (HB_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;

  state_t                state, state_next;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [31:0]           last_nonce;
  logic                  last_valid;
  logic [ACK_W-1:0]      ack_cnt;
  logic [HB_W-1:0]       hb_cnt;
  logic                  src_fifo;
  logic                  flushed;

  logic fifo_empty, fifo_full, dup, hb_due;
  logic push, pop, drop_full;
  logic launch_fifo, launch_hb, launch, ack_expire;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_CNT);
  assign dup        = last_valid && (nonce_in == last_nonce);
  assign hb_due     = HB_EN && (hb_cnt == HB_LAST);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next  = state;
    launch_fifo = 1'b0;
    launch_hb   = 1'b0;
    ack_expire  = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        // A flush cycle never launches: the head it would read is being discarded.
        if (!tx_busy && !flush) begin
          if (!fifo_empty)  launch_fifo = 1'b1;
          else if (hb_due)  launch_hb   = 1'b1;
        end
        if (launch_fifo || launch_hb) state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (ack_cnt == ACK_LAST) begin
          ack_expire = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          pop        = src_fifo && !flushed && !flush;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign launch    = launch_fifo || launch_hb;
  assign push      = nonce_valid && !flush && !dup && (!fifo_full || pop);
  assign drop_full = nonce_valid && !flush && !dup && fifo_full && !pop;

  always_ff @(posedge hash_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: the storage array carries no reset; pointers and count define which entries are live.
  always_ff @(posedge hash_clk) begin
    if (push) mem[wr_ptr] <= nonce_in;
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      tx_send      <= 1'b0;
      tx_data      <= '0;
      fifo_count   <= '0;
      overflow_cnt <= '0;
      timeout_err  <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      last_nonce   <= '0;
      last_valid   <= 1'b0;
      ack_cnt      <= '0;
      hb_cnt       <= '0;
      src_fifo     <= 1'b0;
      flushed      <= 1'b0;
    end else begin
      tx_send <= launch;
      if (launch) begin
        tx_data  <= launch_fifo ? mem[rd_ptr] : HB_WORD;
        src_fifo <= launch_fifo;
      end

      // An in-flight transfer outlives a flush but must not pop the new queue contents.
      if (launch)     flushed <= 1'b0;
      else if (flush) flushed <= 1'b1;

      if (launch)
        ack_cnt <= '0;
      else if (state == WAIT_ACK && !tx_busy && !ack_expire)
        ack_cnt <= ack_cnt + 1'b1;

      if (ack_expire) timeout_err <= 1'b1;

      if (drop_full && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 1'b1;

      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        last_valid <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr     <= wr_ptr + 1'b1;
          last_nonce <= nonce_in;
          last_valid <= 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      fifo_count <= fifo_count + 1'b1;
        else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      end

      if (launch || push || flush)
        hb_cnt <= '0;
      else if (HB_EN && state == IDLE && fifo_empty && !hb_due)
        hb_cnt <= hb_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_nonce_report_queue.sv
// Directed bench for nonce_report_queue: the bench plays mipi_tx and checks queueing,
// duplicate/overflow handling, ack timeout retry, flush and heartbeat timing.
`timescale 1ns/1ps
module tb_nonce_report_queue;

  localparam logic [31:0] HB = 32'h79616B6F;

  logic        hash_clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        nonce_valid = 1'b0;
  logic [31:0] nonce_in = '0;
  logic        tx_busy = 1'b0;
  logic        tx_send;
  logic [31:0] tx_data;
  logic [3:0]  fifo_count;
  logic [7:0]  overflow_cnt;
  logic        timeout_err;

  int          n_checks = 0;
  int          n_fail = 0;
  int          sends = 0;
  logic [31:0] sent_q[$];

  nonce_report_queue #(
    .DEPTH_LOG2 (3),
    .ACK_TIMEOUT(16),
    .HB_CYCLES  (32),
    .HB_WORD    (HB)
  ) dut (
    .hash_clk    (hash_clk),
    .reset       (reset),
    .flush       (flush),
    .nonce_valid (nonce_valid),
    .nonce_in    (nonce_in),
    .tx_busy     (tx_busy),
    .tx_send     (tx_send),
    .tx_data     (tx_data),
    .fifo_count  (fifo_count),
    .overflow_cnt(overflow_cnt),
    .timeout_err (timeout_err)
  );

  always #5 hash_clk = ~hash_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Record every send request; a request while busy is a protocol violation.
  always @(negedge hash_clk) begin
    if (tx_send) begin
      check("send_while_busy", 32'(tx_busy), 32'd0);
      sends++;
      sent_q.push_back(tx_data);
    end
  end

  task automatic tick();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; nonce_valid = 1'b0; nonce_in = '0; tx_busy = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    sends = 0;
    sent_q.delete();
  endtask

  task automatic push_one(input logic [31:0] v);
    nonce_valid = 1'b1;
    nonce_in    = v;
    tick();
    nonce_valid = 1'b0;
  endtask

  // Wait (bounded) for send number 'target', then accept it and complete the packet.
  task automatic serve_one(input int target);
    int waited = 0;
    while (sends < target && waited < 50) begin
      tick();
      waited++;
    end
    check($sformatf("serve_wait_%0d", target), 32'(sends >= target), 32'd1);
    tick();
    tx_busy = 1'b1;
    repeat (3) tick();
    tx_busy = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow_cnt), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);

    // Single hit: send two cycles after the strobe, pop after busy falls
    push_one(32'h1234ABCD);
    check("single_count_k1", 32'(fifo_count), 32'd1);
    check("single_nosend_k1", 32'(tx_send), 32'd0);
    tick();
    check("single_send_k2", 32'(tx_send), 32'd1);
    check("single_data_k2", tx_data, 32'h1234ABCD);
    repeat (2) tick();
    tx_busy = 1'b1;
    repeat (20) tick();
    check("single_count_busy", 32'(fifo_count), 32'd1);
    check("single_data_hold", tx_data, 32'h1234ABCD);
    tx_busy = 1'b0;
    tick();
    check("single_count_done", 32'(fifo_count), 32'd0);
    check("single_sends", 32'(sends), 32'd1);

    // Burst of 10 into a depth-8 queue while the sender is busy
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 10; i++) push_one(32'hA0 + 32'(i));
    check("burst_count", 32'(fifo_count), 32'd8);
    check("burst_overflow", 32'(overflow_cnt), 32'd2);
    check("burst_nosend", 32'(sends), 32'd0);
    tx_busy = 1'b0;
    for (int i = 1; i <= 8; i++) serve_one(i);
    check("burst_sends", 32'(sends), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("burst_order_%0d", i), sent_q[i], 32'hA0 + 32'(i));
    check("burst_drained", 32'(fifo_count), 32'd0);

    // Back-to-back duplicate is suppressed and not counted as overflow
    do_reset();
    push_one(32'h5);
    push_one(32'h5);
    push_one(32'h6);
    serve_one(1);
    serve_one(2);
    repeat (5) tick();
    check("dup_sends", 32'(sends), 32'd2);
    check("dup_first", sent_q[0], 32'h5);
    check("dup_second", sent_q[1], 32'h6);
    check("dup_overflow", 32'(overflow_cnt), 32'd0);
    check("dup_count", 32'(fifo_count), 32'd0);

    // Ack timeout: 16 WAIT_ACK cycles, then retry of the same head
    do_reset();
    push_one(32'hDEADBEEF);
    tick();
    check("to_first_send", 32'(tx_send), 32'd1);
    repeat (15) tick();
    check("to_not_yet", 32'(timeout_err), 32'd0);
    tick();
    check("to_err_set", 32'(timeout_err), 32'd1);
    check("to_idle_nosend", 32'(tx_send), 32'd0);
    check("to_count_kept", 32'(fifo_count), 32'd1);
    tick();
    check("to_resend", 32'(tx_send), 32'd1);
    check("to_resend_data", tx_data, 32'hDEADBEEF);
    tick();
    check("to_sends", 32'(sends), 32'd2);
    check("to_count_after", 32'(fifo_count), 32'd1);

    // Flush during WAIT_DONE of the first transfer; coincident nonce dropped
    do_reset();
    push_one(32'hC1);
    push_one(32'hC2);
    push_one(32'hC3);
    tx_busy = 1'b1;
    tick();
    flush = 1'b1;
    nonce_valid = 1'b1;
    nonce_in = 32'hC4;
    tick();
    flush = 1'b0;
    nonce_valid = 1'b0;
    check("flush_count", 32'(fifo_count), 32'd0);
    repeat (2) tick();
    tx_busy = 1'b0;
    tick();
    repeat (10) tick();
    check("flush_sends", 32'(sends), 32'd1);
    check("flush_sent_data", sent_q[0], 32'hC1);
    check("flush_count_end", 32'(fifo_count), 32'd0);
    check("flush_keep_overflow", 32'(overflow_cnt), 32'd0);
    push_one(32'hC3);
    check("flush_last_cleared", 32'(fifo_count), 32'd1);

    // Heartbeat after 32 idle cycles, then reset abandons the transfer
    do_reset();
    repeat (31) tick();
    check("hb_not_yet", 32'(tx_send), 32'd0);
    tick();
    check("hb_send", 32'(tx_send), 32'd1);
    check("hb_data", tx_data, HB);
    reset = 1'b1;
    tick();
    check("rst_mid_send", 32'(tx_send), 32'd0);
    check("rst_mid_data", tx_data, 32'd0);
    reset = 1'b0;
    repeat (20) tick();
    check("rst_mid_no_retry", 32'(sends), 32'd1);

    // Nonce at cycle 30 pre-empts the heartbeat and restarts the idle count
    do_reset();
    repeat (30) tick();
    push_one(32'h0000BEE5);
    check("hb_pre_nosend", 32'(tx_send), 32'd0);
    tick();
    check("hb_pre_send", 32'(tx_send), 32'd1);
    check("hb_pre_data", tx_data, 32'h0000BEE5);
    tick();
    tx_busy = 1'b1;
    repeat (3) tick();
    tx_busy = 1'b0;
    tick();
    check("hb_pre_drained", 32'(fifo_count), 32'd0);
    repeat (31) tick();
    check("hb_re_not_yet", 32'(tx_send), 32'd0);
    tick();
    check("hb_re_send", 32'(tx_send), 32'd1);
    check("hb_re_data", tx_data, HB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
